// File: rtl/tdm_demux4.sv
// tdm_demux4: four-channel TDM receive demultiplexer.
// Locks to frame_sync, steps a 2-bit slot counter on every valid sample,
// gathers slots 0..2 in shadow registers and publishes a whole frame
// (ch0..ch3) with a one-cycle frame_valid strobe on the slot-3 sample.
// Optional macro TDM_DEMUX4_SYNC_CHECK_EN enables frame_sync placement
// checking with a sync_err pulse; undefined, the block free-runs once locked.
module tdm_demux4 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_sync,
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic [W-1:0] ch2,
  output logic [W-1:0] ch3,
  output logic         frame_valid,
  output logic         locked,
  output logic [1:0]   slot,
  output logic         sync_err
);

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [W-1:0]        shadow_q [NUM_SLOTS];
  logic [W-1:0]        shadow_d [NUM_SLOTS];
  logic [W-1:0]        ch_q     [NUM_SLOTS];
  logic [W-1:0]        ch_d     [NUM_SLOTS];
  logic                fv_q, fv_d;
  logic                err_q, err_d;
  logic                locked_q, locked_d;

  // State, slot counter, shadow and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_q[i] <= '0;
        ch_q[i]     <= '0;
      end
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_q[i] <= shadow_d[i];
        ch_q[i]     <= ch_d[i];
      end
    end
  end

  // Next-state, slot stepping and frame assembly
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    ch_d     = ch_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (din_valid && frame_sync) begin
          shadow_d[0] = din;
          slot_d      = SLOT_W'(1);
          state_d     = LOCKED;
        end
      end

      LOCKED: begin
        if (din_valid) begin
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
          if (frame_sync && (slot_q != '0)) begin
            // Early sync restarts the frame; the partial frame is dropped.
            err_d       = 1'b1;
            shadow_d[0] = din;
            slot_d      = SLOT_W'(1);
          end else if (!frame_sync && (slot_q == '0)) begin
            // Sync missing where expected: lose lock and discard the sample.
            err_d   = 1'b1;
            slot_d  = '0;
            state_d = HUNT;
          end else begin
`endif
            shadow_d[slot_q] = din;
            slot_d           = SLOT_W'(slot_q + SLOT_W'(1));
            if (slot_q == SLOT_W'(NUM_SLOTS - 1)) begin
              ch_d[0] = shadow_q[0];
              ch_d[1] = shadow_q[1];
              ch_d[2] = shadow_q[2];
              ch_d[3] = din;
              fv_d    = 1'b1;
            end
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
          end
`endif
        end
      end

      default: begin
        state_d = HUNT;
        slot_d  = '0;
      end
    endcase

    locked_d = (state_d == LOCKED);
  end

  assign ch0         = ch_q[0];
  assign ch1         = ch_q[1];
  assign ch2         = ch_q[2];
  assign ch3         = ch_q[3];
  assign frame_valid = fv_q;
  assign locked      = locked_q;
  assign slot        = slot_q;
  assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed scenarios plus random traffic, every cycle
// compared against a frame-collecting reference model.
module tb_tdm_demux4;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] ch0, ch1, ch2, ch3;
  logic         frame_valid;
  logic         locked;
  logic [1:0]   slot;
  logic         sync_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: lock flag, samples gathered so far, last published frame
  bit       m_locked;
  int       m_n;
  int       m_frame [4];
  int       m_ch    [4];
  bit       m_fv;
  bit       m_err;

  tdm_demux4 #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .ch0         (ch0),
    .ch1         (ch1),
    .ch2         (ch2),
    .ch3         (ch3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .slot        (slot),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_n      = 0;
    m_fv     = 1'b0;
    m_err    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_frame[i] = 0;
      m_ch[i]    = 0;
    end
  endtask

  task automatic model_append(input int d);
    m_frame[m_n] = d;
    m_n++;
    if (m_n == 4) begin
      for (int i = 0; i < 4; i++) m_ch[i] = m_frame[i];
      m_fv = 1'b1;
      m_n  = 0;
    end
  endtask

  task automatic model_step(input bit v, input bit fs, input int d);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (fs) begin
          m_frame[0] = d;
          m_n        = 1;
          m_locked   = 1'b1;
        end
      end else begin
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
        if (fs && m_n != 0) begin
          m_err      = 1'b1;
          m_frame[0] = d;
          m_n        = 1;
        end else if (!fs && m_n == 0) begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end else begin
          model_append(d);
        end
`else
        model_append(d);
`endif
      end
    end
  endtask

  task automatic compare_all(input string sfx);
    check({"locked", sfx},      32'(locked),      32'(m_locked));
    check({"slot", sfx},        32'(slot),        32'(m_n));
    check({"frame_valid", sfx}, 32'(frame_valid), 32'(m_fv));
    check({"sync_err", sfx},    32'(sync_err),    32'(m_err));
    check({"ch0", sfx},         32'(ch0),         32'(m_ch[0]));
    check({"ch1", sfx},         32'(ch1),         32'(m_ch[1]));
    check({"ch2", sfx},         32'(ch2),         32'(m_ch[2]));
    check({"ch3", sfx},         32'(ch3),         32'(m_ch[3]));
  endtask

  task automatic check_all_zero(input string sfx);
    check({"rst_locked", sfx}, 32'(locked),      32'd0);
    check({"rst_slot", sfx},   32'(slot),        32'd0);
    check({"rst_fv", sfx},     32'(frame_valid), 32'd0);
    check({"rst_err", sfx},    32'(sync_err),    32'd0);
    check({"rst_ch0", sfx},    32'(ch0),         32'd0);
    check({"rst_ch1", sfx},    32'(ch1),         32'd0);
    check({"rst_ch2", sfx},    32'(ch2),         32'd0);
    check({"rst_ch3", sfx},    32'(ch3),         32'd0);
  endtask

  // One clock: drive inputs, let the edge pass, then compare away from it
  task automatic cyc(input bit v, input bit fs, input int d);
    din        = W'(d);
    din_valid  = v;
    frame_sync = fs;
    @(posedge clk);
    #1;
    model_step(v, fs, d & ((1 << W) - 1));
    compare_all("");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_all_zero("");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    rst        = 1'b1;
    model_reset();
    #1;
    check_all_zero("_init");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Lock and single frame 1,0,1,1
    cyc(1, 1, 1); cyc(1, 0, 0); cyc(1, 0, 1); cyc(1, 0, 1);
    cyc(0, 0, 0); cyc(0, 0, 0);

    // Gapped frame A,5,F,3
    cyc(1, 1, 'hA); cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0);
    cyc(1, 0, 'h5); cyc(0, 0, 0);
    cyc(1, 0, 'hF); cyc(1, 0, 'h3); cyc(0, 0, 0);

    // Pre-lock garbage then frame 1,1,0,0
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 'h9 + i);
    cyc(0, 1, 'h7);
    cyc(1, 1, 1); cyc(1, 0, 1); cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);

    // Misplaced sync at slot 2
    cyc(1, 1, 'h9); cyc(1, 0, 'h1); cyc(1, 1, 'h2);
    cyc(1, 0, 'h3); cyc(1, 0, 'h4); cyc(1, 0, 'h5); cyc(0, 0, 0);

    // Missing sync after a full frame
    do_reset();
    cyc(1, 1, 'h6); cyc(1, 0, 'h7); cyc(1, 0, 'h8); cyc(1, 0, 'h9);
    cyc(1, 0, 'hC); cyc(1, 0, 'hD); cyc(1, 0, 'hE); cyc(1, 0, 'hB);
    cyc(0, 0, 0);

    // Back-to-back frames
    do_reset();
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 4; s++) cyc(1, s == 0, f * 4 + s);
    cyc(0, 0, 0);

    // Asynchronous reset mid-frame, then unsynced samples
    cyc(1, 1, 'hA); cyc(1, 0, 'hB);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("_async");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1, 0, 'hF - i);

    // Random traffic, mostly well-placed syncs
    for (int i = 0; i < 3000; i++) begin
      bit v, fs;
      v  = ($urandom_range(0, 9) < 7);
      fs = (m_n == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 29) == 0);
      cyc(v, fs, int'($urandom_range(0, 15)));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
